// File: rtl/dram_arbiter_2core.sv
// Shared single-port DRAM arbiter: the host owns the RAM while stopped, the two cores
// share it round-robin while running. Each access: request, 2-cycle latency, ack pulse.
module dram_arbiter_2core #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  input  logic              c1_req,
  input  logic              c1_wen,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_ack,
  input  logic              c2_req,
  input  logic              c2_wen,
  input  logic [ADDR_W-1:0] c2_addr,
  input  logic [DATA_W-1:0] c2_wdata,
  output logic              c2_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  contention_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_EXT = 2'd0, OWN_C1 = 2'd1, OWN_C2 = 2'd2} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                last_c2_q, last_c2_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                ext_ack_q, ext_ack_d;
  logic                c1_ack_q, c1_ack_d;
  logic                c2_ack_q, c2_ack_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic both_req, grant_ext, grant_c1, grant_c2;

  // last_c2_q=1 means core 2 was granted last, so core 1 wins the next tie
  assign both_req  = run & c1_req & c2_req;
  assign grant_ext = ~run & ext_req;
  assign grant_c1  = run & c1_req & (~c2_req | last_c2_q);
  assign grant_c2  = run & c2_req & (~c1_req | ~last_c2_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_c2_d   = last_c2_q;
    mem_en_d    = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ext_ack_d   = 1'b0;
    c1_ack_d    = 1'b0;
    c2_ack_d    = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (both_req && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        if (grant_ext) begin
          owner_d     = OWN_EXT;
          mem_en_d    = 1'b1;
          mem_wen_d   = ext_wen;
          mem_addr_d  = ext_addr;
          mem_wdata_d = ext_wdata;
          state_d     = ACCESS;
        end else if (grant_c1) begin
          owner_d     = OWN_C1;
          last_c2_d   = 1'b0;
          mem_en_d    = 1'b1;
          mem_wen_d   = c1_wen;
          mem_addr_d  = c1_addr;
          mem_wdata_d = c1_wdata;
          state_d     = ACCESS;
        end else if (grant_c2) begin
          owner_d     = OWN_C2;
          last_c2_d   = 1'b1;
          mem_en_d    = 1'b1;
          mem_wen_d   = c2_wen;
          mem_addr_d  = c2_addr;
          mem_wdata_d = c2_wdata;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // DRAM samples mem_* on this edge; its read data is valid during RESP
        ext_ack_d = (owner_q == OWN_EXT);
        c1_ack_d  = (owner_q == OWN_C1);
        c2_ack_d  = (owner_q == OWN_C2);
        state_d   = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_EXT;
      last_c2_q   <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ext_ack_q   <= 1'b0;
      c1_ack_q    <= 1'b0;
      c2_ack_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_c2_q   <= last_c2_d;
      mem_en_q    <= mem_en_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ext_ack_q   <= ext_ack_d;
      c1_ack_q    <= c1_ack_d;
      c2_ack_q    <= c2_ack_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ext_ack        = ext_ack_q;
  assign c1_ack         = c1_ack_q;
  assign c2_ack         = c2_ack_q;
  assign rdata          = mem_rdata;
  assign mem_en         = mem_en_q;
  assign mem_wen        = mem_wen_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign busy           = (state_q != IDLE);
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_dram_arbiter_2core.sv
// Bench for dram_arbiter_2core: directed scenarios plus random traffic, checked every
// cycle against a timestamp-based transaction model and a reference memory image.
module tb_dram_arbiter_2core;
  localparam int AW   = 9;
  localparam int DW   = 16;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic          ext_req = 1'b0, ext_wen = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_wdata = '0;
  logic          c1_req = 1'b0, c1_wen = 1'b0;
  logic [AW-1:0] c1_addr = '0;
  logic [DW-1:0] c1_wdata = '0;
  logic          c2_req = 1'b0, c2_wen = 1'b0;
  logic [AW-1:0] c2_addr = '0;
  logic [DW-1:0] c2_wdata = '0;
  logic          ext_ack, c1_ack, c2_ack, mem_en, mem_wen, busy;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] contention_cnt;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  int            ref_mem [0:(1<<AW)-1];

  int n_vec = 0, n_miss = 0;
  // model: a grant at edge g puts mem_en up after g, ack after g+1, free again at g+3
  int n_edge = 0, g_edge = -100, g_owner = 0, g_wen = 0, g_addr = 0, g_wdata = 0;
  int g_rdata = 0, pend_wr = 0, last_core = 2, m_cnt = 0;

  always #5 clock = ~clock;

  dram_arbiter_2core #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .run(run),
    .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_ack(ext_ack),
    .c1_req(c1_req), .c1_wen(c1_wen), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_ack(c1_ack),
    .c2_req(c2_req), .c2_wen(c2_wen), .c2_addr(c2_addr), .c2_wdata(c2_wdata), .c2_ack(c2_ack),
    .rdata(rdata), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .contention_cnt(contention_cnt)
  );

  // single-port synchronous DRAM seen by the arbiter
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wen) ram[mem_addr] <= mem_wdata;
      else         mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int idx, input int r, input int w, input int a, input int d);
    case (idx)
      0: begin ext_req = (r != 0); ext_wen = (w != 0); ext_addr = a[AW-1:0]; ext_wdata = d[DW-1:0]; end
      1: begin c1_req = (r != 0); c1_wen = (w != 0); c1_addr = a[AW-1:0]; c1_wdata = d[DW-1:0]; end
      default: begin c2_req = (r != 0); c2_wen = (w != 0); c2_addr = a[AW-1:0]; c2_wdata = d[DW-1:0]; end
    endcase
  endtask

  function automatic int get_ack(input int idx);
    case (idx)
      0: return int'(ext_ack);
      1: return int'(c1_ack);
      default: return int'(c2_ack);
    endcase
  endfunction

  function automatic int get_req(input int idx);
    case (idx)
      0: return int'(ext_req);
      1: return int'(c1_req);
      default: return int'(c2_req);
    endcase
  endfunction

  task automatic check_outputs();
    int d, e_en, e_busy;
    d      = n_edge - g_edge;
    e_en   = (d == 0) ? 1 : 0;
    e_busy = (d == 0 || d == 1) ? 1 : 0;
    check_val("mem_en", int'(mem_en), e_en);
    check_val("busy", int'(busy), e_busy);
    check_val("ext_ack", int'(ext_ack), (d == 1 && g_owner == 0) ? 1 : 0);
    check_val("c1_ack", int'(c1_ack), (d == 1 && g_owner == 1) ? 1 : 0);
    check_val("c2_ack", int'(c2_ack), (d == 1 && g_owner == 2) ? 1 : 0);
    check_val("contention_cnt", int'(contention_cnt), m_cnt);
    if (d == 0) begin
      check_val("mem_wen", int'(mem_wen), g_wen);
      check_val("mem_addr", int'(mem_addr), g_addr);
      if (g_wen != 0) check_val("mem_wdata", int'(mem_wdata), g_wdata);
    end
    if (d == 1 && g_wen == 0) check_val("rdata", int'(rdata), g_rdata);
  endtask

  task automatic tick();
    int   who;
    logic both;
    @(posedge clock);
    n_edge++;
    if (reset_n) begin
      if (pend_wr != 0 && n_edge == g_edge + 1) begin
        ref_mem[g_addr] = g_wdata;
        pend_wr = 0;
      end
      if (n_edge >= g_edge + 3) begin
        both = run && c1_req && c2_req;
        if (both && m_cnt < CMAX) m_cnt++;
        who = -1;
        if (!run) begin
          if (ext_req) who = 0;
        end else if (both) who = (last_core == 1) ? 2 : 1;
        else if (c1_req)   who = 1;
        else if (c2_req)   who = 2;
        if (who >= 0) begin
          g_edge  = n_edge;
          g_owner = who;
          case (who)
            0: begin g_wen = int'(ext_wen); g_addr = int'(ext_addr); g_wdata = int'(ext_wdata); end
            1: begin g_wen = int'(c1_wen); g_addr = int'(c1_addr); g_wdata = int'(c1_wdata); end
            default: begin g_wen = int'(c2_wen); g_addr = int'(c2_addr); g_wdata = int'(c2_wdata); end
          endcase
          if (who != 0) last_core = who;
          pend_wr = g_wen;
          g_rdata = ref_mem[g_addr];
        end
      end
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    #1;
    check_val("rst_mem_en", int'(mem_en), 0);
    check_val("rst_mem_wen", int'(mem_wen), 0);
    check_val("rst_mem_addr", int'(mem_addr), 0);
    check_val("rst_acks", int'({ext_ack, c1_ack, c2_ack}), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_cnt", int'(contention_cnt), 0);
    g_edge = -100; pend_wr = 0; m_cnt = 0; last_core = 2;
    repeat (cycles) tick();
    reset_n = 1'b1;
  endtask

  // one idle cycle first so the arbiter is in IDLE when the request appears
  task automatic txn(input int idx, input int w, input int a, input int d, output int lat, output int rd);
    tick();
    set_req(idx, 1, w, a, d);
    lat = -1;
    rd  = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (get_ack(idx) != 0) begin
        lat = k;
        rd  = int'(rdata);
        break;
      end
    end
    set_req(idx, 0, 0, 0, 0);
    check_val("txn_ack_seen", (lat > 0) ? 1 : 0, 1);
    $display("txn src=%0d %s addr=%0d data=%0d latency=%0d", idx, (w != 0) ? "WR" : "RD", a,
             (w != 0) ? d : rd, lat);
  endtask

  initial begin
    int lat, rd, seen, seen2, g1, g2;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 0;
    @(negedge clock);
    do_reset(3);

    run = 1'b0;
    for (int a = 0; a < 16; a++) txn(0, 1, a, (a * 37 + 5) & 16'hFFFF, lat, rd);

    txn(0, 1, 5, 1234, lat, rd);
    check_val("host_wr_latency", lat, 2);
    txn(0, 0, 5, 0, lat, rd);
    check_val("host_rd_latency", lat, 2);
    check_val("host_rd_data", rd, 1234);

    run = 1'b1;
    txn(1, 1, 20, 77, lat, rd);
    txn(1, 0, 20, 0, lat, rd);
    check_val("c1_rd_latency", lat, 2);
    check_val("c1_rd_data", rd, 77);

    set_req(0, 1, 0, 4, 0);
    seen = 0;
    repeat (20) begin tick(); seen += int'(ext_ack); end
    check_val("ext_ignored_in_run", seen, 0);
    set_req(0, 0, 0, 0, 0);
    run = 1'b0;
    set_req(1, 1, 0, 4, 0);
    seen = 0;
    repeat (20) begin tick(); seen += int'(c1_ack); end
    check_val("c1_ignored_in_host", seen, 0);
    set_req(1, 0, 0, 0, 0);

    run = 1'b1;
    tick();
    set_req(2, 1, 1, 3, 9);
    tick();
    run = 1'b0;
    set_req(1, 1, 0, 4, 0);
    seen = 0; seen2 = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen2 += int'(c1_ack);
      if (c2_ack) begin seen++; set_req(2, 0, 0, 0, 0); end
    end
    check_val("c2_ack_after_run_drop", seen, 1);
    check_val("c1_held_off_after_run_drop", seen2, 0);
    set_req(1, 0, 0, 0, 0);
    txn(0, 0, 3, 0, lat, rd);
    check_val("ram3_after_run_drop", rd, 9);

    run = 1'b1;
    set_req(1, 1, 0, 1, 0);
    set_req(2, 1, 0, 2, 0);
    g1 = 0; g2 = 0;
    repeat (120) begin tick(); g1 += int'(c1_ack); g2 += int'(c2_ack); end
    check_val("grant_balance", ((g1 - g2) <= 1 && (g2 - g1) <= 1) ? 1 : 0, 1);
    check_val("cnt_saturated", int'(contention_cnt), CMAX);
    set_req(1, 0, 0, 0, 0);
    set_req(2, 0, 0, 0, 0);
    repeat (3) tick();

    tick();
    set_req(1, 1, 1, 7, 16'hBEEF);
    tick();
    do_reset(2);
    set_req(1, 0, 0, 0, 0);
    txn(2, 0, 7, 0, lat, rd);
    check_val("c2_rd_after_reset_latency", lat, 2);
    check_val("aborted_write_not_applied", rd, 7 * 37 + 5);

    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (get_req(i) != 0 && get_ack(i) != 0) begin
          if ($urandom_range(0, 3) == 0)
            set_req(i, 1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 65535));
          else
            set_req(i, 0, 0, 0, 0);
        end else if (get_req(i) == 0 && $urandom_range(0, 2) == 0) begin
          set_req(i, 1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 65535));
        end
      end
      if ($urandom_range(0, 29) == 0) run = ~run;
      tick();
    end
    for (int i = 0; i < 3; i++) set_req(i, 0, 0, 0, 0);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/dram_arbiter_2core.md
Name: dram_arbiter_2core

Overview:
- Arbitrates the single shared data RAM (DRAM) between core 1, core 2 and the external host load/readback port.
- Sits between the two processor cores, the testbench/host interface and the single-port synchronous DRAM inside top_control_2.
- Host owns the RAM while the processor is stopped (run=0); the cores share it round-robin while running (run=1).
- Every access is a single-word transaction: request, 2-cycle latency, then an acknowledge pulse.

Parameters:
ADDR_W, 9, DRAM address width
DATA_W, 16, DRAM data width
CNT_W, 16, width of the saturating contention counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
run  in  1  0 = host mode, 1 = core mode (driven from the top-level start)
ext_req  in  1  host access request, held until ext_ack
ext_wen  in  1  host write (1) / read (0)
ext_addr  in  ADDR_W  host address
ext_wdata  in  DATA_W  host write data
ext_ack  out  1  host transaction done, one-cycle pulse
c1_req, c2_req  in  1 each  core access request, held until own ack
c1_wen, c2_wen  in  1 each  core write (1) / read (0)
c1_addr, c2_addr  in  ADDR_W each  core address
c1_wdata, c2_wdata  in  DATA_W each  core write data
c1_ack, c2_ack  out  1 each  core transaction done, one-cycle pulse
rdata  out  DATA_W  read data broadcast to all requesters (= mem_rdata), valid only in an ack cycle of a read
mem_en  out  1  DRAM enable, registered
mem_wen  out  1  DRAM write enable, registered
mem_addr  out  ADDR_W  DRAM address, registered
mem_wdata  out  DATA_W  DRAM write data, registered
mem_rdata  in  DATA_W  DRAM read data, valid the cycle after mem_en with mem_wen=0
busy  out  1  high in ACCESS and RESP states
contention_cnt  out  CNT_W  cycles in which IDLE saw c1_req and c2_req both high while run=1; saturates at all-ones

Behaviour:
- Reset (async, reset_n=0) clears all registers immediately:
  - state=IDLE; mem_en, mem_wen, mem_addr, mem_wdata = 0.
  - All acks = 0, busy = 0, contention_cnt = 0.
  - Round-robin pointer set so core 1 has next priority.
- Reset mid-transaction aborts the transaction with no ack. The requester must re-issue after reset_n rises.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, eligible requesters:
  - run=0: ext_req only; core requests are ignored (not queued).
  - run=1: c1_req, c2_req only; ext_req is ignored.
- IDLE, winner selection:
  - The winner's wen, addr and wdata are registered onto the mem_* outputs and mem_en=1. Next state is ACCESS.
  - No eligible request: stay in IDLE with mem_en=0.
- Round robin (run=1): if both cores request, the core not granted last wins. If only one requests, it wins and becomes the last-granted core.
- ACCESS (single cycle): the DRAM samples the mem_* signals. On the next edge mem_en and mem_wen drop to 0 and the owner's ack is set. Next state is RESP.
- RESP (single cycle):
  - The owner's ack is high; rdata = mem_rdata is valid for reads.
  - On the next edge the ack clears and the FSM returns to IDLE.
- Latency: request sampled at edge E0, ack high in the cycle between E1 and E2, back in IDLE after E2. Read data is captured by the requester at E2.
- Throughput: one transaction per 3 cycles.
- Handshake rules:
  - The requester holds req, wen, addr and wdata stable until it sees ack, then drops req before E3.
  - A req still high at E3 is treated as a new transaction.
  - Request inputs change only what is sampled in IDLE. Changes during ACCESS/RESP have no effect.
- run toggling during ACCESS/RESP: the in-flight transaction completes and is acked normally. The new mode applies from the next IDLE.
- Exactly one ack is high per RESP cycle; acks are never high in IDLE or ACCESS.
- contention_cnt increments only in IDLE with run=1 and both core requests high. It holds at 2^CNT_W-1.

Test Plan:
- Reset mid-transaction: assert reset_n=0 while in ACCESS -> mem_en=0, no ack, contention_cnt=0, state IDLE; release then c2 read -> c2 served normally.
- Host write then read (run=0): ext write addr=5 data=16'd1234, then ext read addr=5 -> mem_en/mem_wen=1 one cycle after req, ext_ack 2 cycles after req; read ext_ack cycle rdata=1234.
- Single core read (run=1): c1 read addr=9'd20 where RAM holds 77 -> c1_ack 2 cycles after req, rdata=77, c2_ack stays 0.
- Simultaneous core requests, both held continuously (re-requesting after each ack) -> grants alternate c1,c2,c1,c2 with 3-cycle spacing; contention_cnt increments once per IDLE visit with both requests high.
- Mode isolation: run=1 with ext_req=1 held for 20 cycles -> ext_ack never asserts, mem_en stays 0 without core reqs. run=0 with c1_req -> c1_ack never asserts.
- run drop during ACCESS of a c2 write addr=3 data=9 -> c2_ack still pulses and RAM[3]=9; pending c1_req not granted afterwards while run=0.
